// File: rtl/length_pack_16bit_if.sv
// Handshake and vector bus between a length-pack writer and its driver.
// data_o uses the same unpacked array format the length finder consumes.
interface length_pack_16bit_if #(
    parameter int WIDTH = 16,
    parameter int IDXW  = 4
);
    logic             start_i;
    logic [IDXW-1:0]  len_i;
    logic             bit_valid_i;
    logic             bit_i;
    logic             data_o [0:WIDTH-1];
    logic             busy_o;
    logic             done_o;
    logic             valid_o;

    modport master (
        output start_i, len_i, bit_valid_i, bit_i,
        input  data_o, busy_o, done_o, valid_o
    );

    modport slave (
        input  start_i, len_i, bit_valid_i, bit_i,
        output data_o, busy_o, done_o, valid_o
    );
endinterface

// File: rtl/length_pack_16bit.sv
// Builds a vector whose highest set bit is at len_i, filling the entries
// below the marker from a serial payload stream, one bit per accepted beat.
module length_pack_16bit #(
    parameter int WIDTH = 16,
    parameter int IDXW  = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    length_pack_16bit_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    localparam logic [IDXW-1:0] ONE = IDXW'(1);

    state_t            state_q, state_d;
    logic [IDXW-1:0]   len_q, len_d;
    logic [IDXW-1:0]   k_q, k_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;

    logic start_acc;
    logic beat_acc;
    logic last_beat;

    assign start_acc = (state_q == IDLE) && bus.start_i;
    assign beat_acc  = (state_q == LOAD) && bus.bit_valid_i;
    // k never reaches len, so the marker entry is never overwritten
    assign last_beat = beat_acc && (k_q == (len_q - ONE));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start_i) state_d = (bus.len_i == '0) ? DONE : LOAD;
            LOAD:    if (last_beat) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        len_d   = len_q;
        k_d     = k_q;
        data_d  = data_q;
        valid_d = valid_q;
        if (start_acc) begin
            len_d              = bus.len_i;
            k_d                = '0;
            data_d             = '0;
            data_d[bus.len_i]  = 1'b1;
            valid_d            = 1'b0;
        end else if (beat_acc) begin
            data_d[k_q] = bus.bit_i;
            if (!last_beat) k_d = k_q + ONE;
        end
        if (state_d == DONE) valid_d = 1'b1;
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            len_q   <= '0;
            k_q     <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            len_q   <= len_d;
            k_q     <= k_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        bus.busy_o  = (state_q != IDLE);
        bus.done_o  = done_q;
        bus.valid_o = valid_q;
        for (int i = 0; i < WIDTH; i++) begin
            bus.data_o[i] = data_q[i];
        end
    end
endmodule

// File: doc/length_pack_16bit.md
Name: length_pack_16bit

Overview:
- Writer-side counterpart of the 16-bit length finder. Builds a 16-entry bit vector whose highest set bit sits at a requested index len_i, so the length finder recovers exactly len_i from it.
- Bits below the marker are filled from a serial payload stream, one bit per accepted beat.
- Drives the data_i array of the length finder or any downstream consumer of the same array format.

Parameters:
- WIDTH, 16, number of entries in the output vector; must be a power of two.
- IDXW, 4, index width; equals log2(WIDTH).

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- start_i  input  1  request to build a new vector; accepted only in IDLE.
- len_i  input  IDXW  marker index; sampled on the accepted start.
- bit_valid_i  input  1  payload beat valid; honoured only in LOAD.
- bit_i  input  1  payload bit; sampled together with bit_valid_i.
- data_o  output  1 x [0:WIDTH-1]  built vector; unpacked array, same format the length finder consumes.
- busy_o  output  1  high whenever state is not IDLE.
- done_o  output  1  one-cycle pulse when the vector is complete.
- valid_o  output  1  data_o holds a complete vector.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, all data_o entries=0, busy_o=0, done_o=0, valid_o=0, internal len register=0, write counter=0. Assertion mid-operation aborts immediately; no partial vector is flagged valid.
- States: IDLE, LOAD, DONE.
- IDLE, start_i=1 (accepted) at edge N:
  - len register <= len_i; write counter k <= 0.
  - data_o <= all 0 except data_o[len_i] <= 1; valid_o <= 0.
  - len_i==0: next state DONE. Otherwise: next state LOAD.
- IDLE, start_i=0: hold all outputs.
- LOAD, on each edge with bit_valid_i=1:
  - data_o[k] <= bit_i.
  - If k==len-1: next state DONE. Else: k <= k+1.
- LOAD, bit_valid_i=0: no change (stall, unbounded).
- DONE: lasts exactly one cycle, with done_o=1 and valid_o=1. Next state IDLE.
- done_o is a registered output, high only in DONE.
- valid_o rises with done_o and stays high in IDLE until the next accepted start.
- Latency from accepted start to done_o:
  - len=0: 1 cycle.
  - len=L: L accepted beats plus 1 cycle.
  - With beats back-to-back, done_o appears L+1 cycles after the start edge.
- start_i while busy_o=1: ignored, with no effect on the len register or data_o.
- bit_valid_i in IDLE or DONE: ignored.
- Entries above the marker are always 0 and the marker entry is always 1. Payload can never overwrite the marker because k < len always holds.
- Widths: k and the len register are IDXW bits. len=WIDTH-1 (15) writes entries 0..14; there is no wrap-around.
- Start accepted in the IDLE cycle immediately after DONE: legal, giving back-to-back vectors with one IDLE cycle between them.

Test Plan:
- Reset mid-LOAD (len=9, after 4 beats) -> immediately data_o all 0, busy_o=0, valid_o=0, done_o=0. A following start with len=2 completes normally.
- start with len=0 -> next cycle done_o=1, valid_o=1, data_o[0]=1, data_o[1..15]=0. Length finder fed this vector reports index 0.
- start with len=5, beats 1,0,1,1,0 back-to-back -> done_o 6 cycles after the start edge; data_o[0..5]=1,0,1,1,0,1; data_o[6..15]=0.
- start with len=15, 15 beats of 1 with bit_valid_i dropped for 3 cycles mid-stream -> done_o delayed by exactly 3 cycles; data_o all 1. Length finder reports index 15.
- start_i re-asserted with len=3 during a len=7 build -> ignored; final vector has marker at 7 and exactly 7 beats consumed.
- Back-to-back: len=1 (beat 1) then start the cycle after done_o with len=2 (beats 0,0) -> valid_o drops the cycle after the second start; final data_o[0..2]=0,0,1, remaining entries 0.
